// File: rtl/uart_pkg.sv
// Shared types and constants for the buffered UART receiver.
// Holds the receive FSM state type, the parity mode codes, the 40 MHz baud divisors and a parity helper.
// Has no logic, no latency and no backpressure of its own.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    PARITY    = 3'd3,
    STOP      = 3'd4,
    WAIT_HIGH = 3'd5
  } rx_state_t;

  localparam logic [1:0] PAR_NONE     = 2'd0;
  localparam logic [1:0] PAR_EVEN     = 2'd1;
  localparam logic [1:0] PAR_ODD      = 2'd2;
  localparam logic [1:0] PAR_NONE_ALT = 2'd3;

  // Bit period minus one at a 40 MHz clock.
  localparam int BAUD_DIV_115200 = 346;
  localparam int BAUD_DIV_230400 = 173;
  localparam int BAUD_DIV_460800 = 86;

  // Expected parity bit. Unused upper data bits are zero, so they do not disturb the XOR.
  function automatic logic parity_bit(input logic [7:0] dat, input logic [1:0] mode);
    return (^dat) ^ (mode == PAR_ODD);
  endfunction

endpackage

// File: rtl/uart_rx_buf_if.sv
// Receive-FIFO read port between the UART receiver and the command decoder.
// master: receiver side (drives head byte, empty, count). slave: consumer side (drives the pop strobe).
// Pop in cycle n shows the next head in cycle n+1. The consumer paces reads, and pops of an empty FIFO are ignored.
interface uart_rx_buf_if #(
  parameter int FIFO_DEPTH = 16
);
  logic                          uld_rx_data;
  logic [7:0]                    rx_data;
  logic                          rx_empty;
  logic [$clog2(FIFO_DEPTH):0]   rx_count;

  modport master (input uld_rx_data, output rx_data, output rx_empty, output rx_count);
  modport slave  (output uld_rx_data, input rx_data, input rx_empty, input rx_count);
endinterface

// File: rtl/sync_fifo.sv
// Generic first-word-fall-through FIFO. Ports: clk, reset (async, active-low), flush_i, push_i/push_dat_i,
// pop_i, head_dat_o (0 when empty), full_o, empty_o, count_o.
// Latency: a push is visible at the head one cycle later. A pop shows the next head one cycle later.
// Backpressure: a push while full is dropped unless a pop happens in the same cycle. A pop while empty is ignored.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_dat_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_dat_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [AW:0]      count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign empty_o    = (count_q == '0);
  assign full_o     = (count_q == (AW+1)'(DEPTH));
  assign count_o    = count_q;
  assign head_dat_o = empty_o ? '0 : mem_q[rptr_q];

  // A pop frees the slot, so a full FIFO still accepts a push in the same cycle.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (flush_i) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      // Pointers wrap naturally because DEPTH is a power of two.
      if (do_push) wptr_d = wptr_q + AW'(1);
      if (do_pop)  rptr_d = rptr_q + AW'(1);
      count_d = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= push_dat_i;
  end

endmodule

// File: rtl/uart_rx_buf.sv
// UART receiver with runtime baud divisor, 5-8 data bits, optional parity, 1/2 stop bits, sticky errors and a receive FIFO.
// Latency: the byte is pushed the cycle after the final stop sample, and the head is valid one cycle later (mid-stop + 2 + SYNC_STAGES).
// Backpressure: none toward the line. When the FIFO is full, the byte is dropped and overrun is set, unless a pop happens in the same cycle.
// Ports: clk, reset (async, active-low), rx_enable (low = synchronous flush), baud_div/data_bits/parity_mode/two_stop
// (latched per frame), rx_in (async line), rxb (FIFO read port), err_clr, and the sticky frame_err/parity_err/overrun flags.
// Build option: define UART_RX_PARITY_EN to include the PARITY state and parity_err. Without it, parity_err is tied to 0.
module uart_rx_buf
  import uart_pkg::*;
#(
  parameter int DIV_W       = 16,
  parameter int FIFO_DEPTH  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             rx_enable,
  input  logic [DIV_W-1:0] baud_div,
  input  logic [1:0]       data_bits,
  input  logic [1:0]       parity_mode,
  input  logic             two_stop,
  input  logic             rx_in,
  uart_rx_buf_if.master    rxb,
  input  logic             err_clr,
  output logic             frame_err,
  output logic             parity_err,
  output logic             overrun
);

  rx_state_t              state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [DIV_W-1:0]       timer_q, timer_d, div_q, div_d, div_eff;
  logic [1:0]             nbits_q, nbits_d;
  logic                   two_stop_q, two_stop_d, stop2_q, stop2_d;
  logic [2:0]             bit_cnt_q, bit_cnt_d;
  logic [7:0]             data_q, data_d, push_dat_q, push_dat_d;
  logic                   push_q, push_d;
  logic                   frame_err_q, frame_err_d, overrun_q, overrun_d;
  logic                   frame_set, par_set, par_en, rx_s, tick, fifo_full;

  assign rx_s    = sync_q[SYNC_STAGES-1];
  assign tick    = (timer_q == '0);
  assign div_eff = (baud_div < DIV_W'(3)) ? DIV_W'(3) : baud_div;

`ifdef UART_RX_PARITY_EN
  logic [1:0] par_q, par_d;
  logic       parity_err_q, parity_err_d;
  assign par_en     = (par_q == PAR_EVEN) || (par_q == PAR_ODD);
  assign parity_err = parity_err_q;
  assign parity_err_d = rx_enable & (par_set | (parity_err_q & ~err_clr));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      par_q        <= PAR_NONE;
      parity_err_q <= 1'b0;
    end else begin
      par_q        <= par_d;
      parity_err_q <= parity_err_d;
    end
  end
`else
  logic unused_parity;
  assign unused_parity = ^{parity_mode, par_set};
  assign par_en        = 1'b0;
  assign parity_err    = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    div_d      = div_q;
    nbits_d    = nbits_q;
    two_stop_d = two_stop_q;
    bit_cnt_d  = bit_cnt_q;
    data_d     = data_q;
    stop2_d    = stop2_q;
    push_d     = 1'b0;
    push_dat_d = push_dat_q;
    frame_set  = 1'b0;
    par_set    = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d      = par_q;
`endif
    sync_d     = {sync_q[SYNC_STAGES-2:0], rx_in};

    if (state_q != IDLE && state_q != WAIT_HIGH)
      timer_d = tick ? div_q : timer_q - DIV_W'(1);

    case (state_q)
      IDLE: if (!rx_s) begin
        // Latch the frame format here so that mid-frame changes only affect the next frame.
        state_d    = START;
        div_d      = div_eff;
        nbits_d    = data_bits;
        two_stop_d = two_stop;
`ifdef UART_RX_PARITY_EN
        par_d      = parity_mode;
`endif
        timer_d    = div_eff >> 1;
        bit_cnt_d  = '0;
        data_d     = '0;
        stop2_d    = 1'b0;
      end
      START: if (tick) state_d = rx_s ? IDLE : DATA;
      DATA: if (tick) begin
        data_d[bit_cnt_q] = rx_s;
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'(nbits_q) + 3'd4) state_d = par_en ? PARITY : STOP;
      end
`ifdef UART_RX_PARITY_EN
      PARITY: if (tick) begin
        par_set = (rx_s != parity_bit(data_q, par_q));
        state_d = STOP;
      end
`endif
      STOP: if (tick) begin
        if (!rx_s) begin
          frame_set = 1'b1;
          state_d   = WAIT_HIGH;
        end else if (two_stop_q && !stop2_q) begin
          stop2_d = 1'b1;
        end else begin
          // Return to IDLE from mid-stop so that an immediately following start edge is caught.
          push_d     = 1'b1;
          push_dat_d = data_q;
          state_d    = IDLE;
        end
      end
      WAIT_HIGH: if (rx_s) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (!rx_enable) begin
      state_d    = IDLE;
      sync_d     = '1;
      timer_d    = '0;
      div_d      = '0;
      nbits_d    = '0;
      two_stop_d = 1'b0;
      bit_cnt_d  = '0;
      data_d     = '0;
      stop2_d    = 1'b0;
      push_dat_d = '0;
`ifdef UART_RX_PARITY_EN
      par_d      = PAR_NONE;
`endif
    end
  end

  // A set event wins over err_clr in the same cycle.
  assign frame_err_d = rx_enable & (frame_set | (frame_err_q & ~err_clr));
  assign overrun_d   = rx_enable & ((push_q & fifo_full & ~rxb.uld_rx_data) | (overrun_q & ~err_clr));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      sync_q      <= '1;
      timer_q     <= '0;
      div_q       <= '0;
      nbits_q     <= '0;
      two_stop_q  <= 1'b0;
      bit_cnt_q   <= '0;
      data_q      <= '0;
      stop2_q     <= 1'b0;
      push_q      <= 1'b0;
      push_dat_q  <= '0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync_q      <= sync_d;
      timer_q     <= timer_d;
      div_q       <= div_d;
      nbits_q     <= nbits_d;
      two_stop_q  <= two_stop_d;
      bit_cnt_q   <= bit_cnt_d;
      data_q      <= data_d;
      stop2_q     <= stop2_d;
      push_q      <= push_d & rx_enable;
      push_dat_q  <= push_dat_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .flush_i    (!rx_enable),
    .push_i     (push_q),
    .push_dat_i (push_dat_q),
    .pop_i      (rxb.uld_rx_data),
    .head_dat_o (rxb.rx_data),
    .full_o     (fifo_full),
    .empty_o    (rxb.rx_empty),
    .count_o    (rxb.rx_count)
  );

endmodule
